// File: rtl/garegga_gp9001_bridge_if.sv
// ---------------------------------------------------------------------------
// garegga_gp9001_bridge_if
//
// Bundles the CPU bus-glue side and the GCU op-strobe side of the GP9001
// bridge.
//   master : the bridge view (drives CPU_DOUT/CPU_ACK, GP9001CS, GP9001DIN,
//            the op flags and TIMEOUT_ERR)
//   slave  : the environment view (CPU glue + GCU), directions reversed
// ---------------------------------------------------------------------------
interface garegga_gp9001_bridge_if;
  // CPU bus glue
  logic        CPU_CS;
  logic        CPU_RNW;
  logic [2:0]  CPU_ADDR;
  logic [15:0] CPU_DIN;
  logic [15:0] CPU_DOUT;
  logic        CPU_ACK;
  // GCU op-strobe bus
  logic        GP9001CS;
  logic        GP9001ACK;
  logic [15:0] GP9001DIN;
  logic [15:0] GP9001DOUT;
  logic        GP9001_OP_SELECT_REG;
  logic        GP9001_OP_WRITE_REG;
  logic        GP9001_OP_WRITE_RAM;
  logic        GP9001_OP_READ_RAM_H;
  logic        GP9001_OP_READ_RAM_L;
  logic        GP9001_OP_SET_RAM_PTR;
  // GCU sync status and error flag
  logic        CPU_HSYNC;
  logic        CPU_VSYNC;
  logic        CPU_FBLANK;
  logic        TIMEOUT_ERR;

  modport master (
    input  CPU_CS, CPU_RNW, CPU_ADDR, CPU_DIN,
    output CPU_DOUT, CPU_ACK,
    output GP9001CS, GP9001DIN,
    input  GP9001ACK, GP9001DOUT,
    output GP9001_OP_SELECT_REG, GP9001_OP_WRITE_REG, GP9001_OP_WRITE_RAM,
    output GP9001_OP_READ_RAM_H, GP9001_OP_READ_RAM_L, GP9001_OP_SET_RAM_PTR,
    input  CPU_HSYNC, CPU_VSYNC, CPU_FBLANK,
    output TIMEOUT_ERR
  );

  modport slave (
    output CPU_CS, CPU_RNW, CPU_ADDR, CPU_DIN,
    input  CPU_DOUT, CPU_ACK,
    input  GP9001CS, GP9001DIN,
    output GP9001ACK, GP9001DOUT,
    input  GP9001_OP_SELECT_REG, GP9001_OP_WRITE_REG, GP9001_OP_WRITE_RAM,
    input  GP9001_OP_READ_RAM_H, GP9001_OP_READ_RAM_L, GP9001_OP_SET_RAM_PTR,
    output CPU_HSYNC, CPU_VSYNC, CPU_FBLANK,
    input  TIMEOUT_ERR
  );
endinterface

// File: rtl/garegga_gp9001_bridge.sv
// ---------------------------------------------------------------------------
// garegga_gp9001_bridge
//
// CPU-side initiator for the GP9001 op-strobe interface. Each 68000 word
// access to the GP9001 window becomes exactly one GCU op (or a local status /
// open-bus response), followed by a single-cycle CPU_ACK.
//
// Ports:
//   CLK   : system clock, rising edge
//   RESET : asynchronous, active-high
//   bus   : garegga_gp9001_bridge_if.master (CPU glue, GCU op bus, sync
//           status inputs, sticky TIMEOUT_ERR)
// Parameters:
//   TIMEOUT  : cycles to wait for GP9001ACK before aborting (1..255)
//   OPEN_BUS : read data for unmapped offsets and aborted accesses
// ---------------------------------------------------------------------------
module garegga_gp9001_bridge #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [15:0] OPEN_BUS = 16'hFFFF
) (
  input  logic                    CLK,
  input  logic                    RESET,
  garegga_gp9001_bridge_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOCAL,
    S_REQ,
    S_RELEASE,
    S_DONE
  } state_t;

  // One-hot op vector bit positions
  localparam int OP_SELECT_REG  = 0;
  localparam int OP_WRITE_REG   = 1;
  localparam int OP_WRITE_RAM   = 2;
  localparam int OP_READ_RAM_H  = 3;
  localparam int OP_READ_RAM_L  = 4;
  localparam int OP_SET_RAM_PTR = 5;

  // The counter holds the number of REQ cycles already spent without ACK,
  // so abort happens on the edge closing the TIMEOUT-th REQ cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [5:0]  op_reg, op_next;
  logic        rnw_reg, rnw_next;
  logic        status_rd_reg, status_rd_next;
  logic [15:0] din_reg, din_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [15:0] dout_reg, dout_next;
  logic        ack_reg, ack_next;
  logic        terr_reg, terr_next;

  logic [5:0]  op_dec;
  logic        in_req;

  // Address map decode of the live CPU request; zero means "not a GCU op".
  always_comb begin
    op_dec = '0;
    if (bus.CPU_RNW) begin
      case (bus.CPU_ADDR)
        3'd2:    op_dec[OP_READ_RAM_H] = 1'b1;
        3'd3:    op_dec[OP_READ_RAM_L] = 1'b1;
        default: op_dec = '0;
      endcase
    end else begin
      case (bus.CPU_ADDR)
        3'd0:       op_dec[OP_SET_RAM_PTR] = 1'b1;
        3'd2, 3'd3: op_dec[OP_WRITE_RAM]   = 1'b1;
        3'd4:       op_dec[OP_SELECT_REG]  = 1'b1;
        3'd6:       op_dec[OP_WRITE_REG]   = 1'b1;
        default:    op_dec = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg     <= S_IDLE;
      op_reg        <= '0;
      rnw_reg       <= 1'b0;
      status_rd_reg <= 1'b0;
      din_reg       <= '0;
      cnt_reg       <= '0;
      dout_reg      <= '0;
      ack_reg       <= 1'b0;
      terr_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      rnw_reg       <= rnw_next;
      status_rd_reg <= status_rd_next;
      din_reg       <= din_next;
      cnt_reg       <= cnt_next;
      dout_reg      <= dout_next;
      ack_reg       <= ack_next;
      terr_reg      <= terr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    rnw_next       = rnw_reg;
    status_rd_next = status_rd_reg;
    din_next       = din_reg;
    cnt_next       = cnt_reg;
    dout_next      = dout_reg;
    ack_next       = 1'b0;
    terr_next      = terr_reg;

    case (state_reg)
      S_IDLE: begin
        if (bus.CPU_CS) begin
          op_next        = op_dec;
          rnw_next       = bus.CPU_RNW;
          status_rd_next = bus.CPU_RNW && (bus.CPU_ADDR == 3'd6);
          din_next       = bus.CPU_DIN;
          cnt_next       = '0;
          state_next     = (op_dec != '0) ? S_REQ : S_LOCAL;
        end
      end

      S_LOCAL: begin
        dout_next  = status_rd_reg
                   ? {13'b0, bus.CPU_HSYNC, bus.CPU_VSYNC, bus.CPU_FBLANK}
                   : OPEN_BUS;
        ack_next   = 1'b1;
        state_next = S_DONE;
      end

      S_REQ: begin
        // ACK is tested first so a same-cycle ACK beats the timeout.
        if (bus.GP9001ACK) begin
          dout_next  = rnw_reg ? bus.GP9001DOUT : 16'h0000;
          ack_next   = 1'b1;
          state_next = S_RELEASE;
        end else if (cnt_reg == CNT_LAST) begin
          dout_next  = OPEN_BUS;
          ack_next   = 1'b1;
          terr_next  = 1'b1;
          state_next = S_RELEASE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      // Even after an abort the GCU must drop ACK before we move on, so a
      // late ACK can never be mistaken for the next transaction's.
      S_RELEASE: begin
        if (!bus.GP9001ACK) state_next = S_DONE;
      end

      S_DONE: begin
        if (!bus.CPU_CS) state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  // Request side is decoded from the state register so an async reset
  // removes GP9001CS and the op flags immediately.
  assign in_req = (state_reg == S_REQ);

  assign bus.GP9001CS              = in_req;
  assign bus.GP9001DIN             = (in_req && !rnw_reg) ? din_reg : 16'h0000;
  assign bus.GP9001_OP_SELECT_REG  = in_req && op_reg[OP_SELECT_REG];
  assign bus.GP9001_OP_WRITE_REG   = in_req && op_reg[OP_WRITE_REG];
  assign bus.GP9001_OP_WRITE_RAM   = in_req && op_reg[OP_WRITE_RAM];
  assign bus.GP9001_OP_READ_RAM_H  = in_req && op_reg[OP_READ_RAM_H];
  assign bus.GP9001_OP_READ_RAM_L  = in_req && op_reg[OP_READ_RAM_L];
  assign bus.GP9001_OP_SET_RAM_PTR = in_req && op_reg[OP_SET_RAM_PTR];

  assign bus.CPU_DOUT    = dout_reg;
  assign bus.CPU_ACK     = ack_reg;
  assign bus.TIMEOUT_ERR = terr_reg;

endmodule

// File: tb/tb_garegga_gp9001_bridge.sv
// ---------------------------------------------------------------------------
// tb_garegga_gp9001_bridge
//
// Drives CPU accesses and plays the GCU (configurable ACK delay and hold),
// comparing every access against an address-map table and timing rules.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_garegga_gp9001_bridge;

  localparam int          TO       = 8;
  localparam logic [15:0] OPEN_BUS = 16'hFFFF;

  // Op flag vector as seen by the bench:
  // {SET_RAM_PTR, READ_RAM_L, READ_RAM_H, WRITE_RAM, WRITE_REG, SELECT_REG}
  localparam logic [5:0] F_SELECT = 6'b000001;
  localparam logic [5:0] F_WREG   = 6'b000010;
  localparam logic [5:0] F_WRAM   = 6'b000100;
  localparam logic [5:0] F_RDH    = 6'b001000;
  localparam logic [5:0] F_RDL    = 6'b010000;
  localparam logic [5:0] F_PTR    = 6'b100000;

  logic CLK;
  logic RESET;
  garegga_gp9001_bridge_if bus ();

  garegga_gp9001_bridge #(.TIMEOUT(TO), .OPEN_BUS(OPEN_BUS)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  logic exp_terr = 1'b0;

  // Expected op per {rnw, addr}; zero = no GCU transaction.
  logic [5:0] op_map [16];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] flags_now();
    return {bus.GP9001_OP_SET_RAM_PTR, bus.GP9001_OP_READ_RAM_L, bus.GP9001_OP_READ_RAM_H,
            bus.GP9001_OP_WRITE_RAM, bus.GP9001_OP_WRITE_REG, bus.GP9001_OP_SELECT_REG};
  endfunction

  // One CPU access, entered and left at a negedge. ack_delay = cycle of
  // GP9001CS on which the GCU raises ACK (0 or > TO means never).
  task automatic do_access(input string name, input logic rnw, input logic [2:0] addr,
                           input logic [15:0] din, input int ack_delay, input int ack_hold,
                           input logic [15:0] gcu_data, input int cs_hold);
    logic [5:0]  eop;
    logic        mapped, to, cs_prev;
    logic [15:0] exp_dout, exp_din, dout;
    int exp_cs, exp_ack_cyc, cs_cycles, first_cs, acks, ack_cyc, txn, op_bad, din_bad;
    int hold_cnt, settle, done;

    eop      = op_map[{rnw, addr}];
    mapped   = (eop != 6'b0);
    to       = mapped && !(ack_delay >= 1 && ack_delay <= TO);
    exp_cs   = !mapped ? 0 : (to ? TO : ack_delay);
    exp_ack_cyc = mapped ? 1 + exp_cs : 2;
    exp_din  = (mapped && !rnw) ? din : 16'h0000;
    if (to)                       exp_dout = OPEN_BUS;
    else if (mapped)              exp_dout = rnw ? gcu_data : 16'h0000;
    else if (rnw && addr == 3'd6) exp_dout = {13'b0, bus.CPU_HSYNC, bus.CPU_VSYNC, bus.CPU_FBLANK};
    else                          exp_dout = OPEN_BUS;
    if (to) exp_terr = 1'b1;

    cs_cycles = 0; first_cs = -1; acks = 0; ack_cyc = -1; txn = 0; op_bad = 0; din_bad = 0;
    hold_cnt = 0; settle = 0; done = 0; cs_prev = 1'b0; dout = 16'h0;

    bus.CPU_CS = 1'b1; bus.CPU_RNW = rnw; bus.CPU_ADDR = addr; bus.CPU_DIN = din;

    for (int cyc = 1; cyc <= 300 && done == 0; cyc++) begin
      @(negedge CLK);
      if (bus.GP9001CS && !cs_prev) txn++;
      if (bus.GP9001CS) begin
        cs_cycles++;
        if (first_cs < 0) first_cs = cyc;
        if (flags_now() !== eop) op_bad++;
        if (bus.GP9001DIN !== exp_din) din_bad++;
      end else if (flags_now() != 6'b0) begin
        op_bad++;
      end
      if (bus.CPU_ACK) begin
        acks++;
        ack_cyc = cyc;
        dout = bus.CPU_DOUT;
      end
      cs_prev = bus.GP9001CS;

      // GCU responder
      if (bus.GP9001ACK && !bus.GP9001CS) begin
        hold_cnt++;
        if (hold_cnt > ack_hold) bus.GP9001ACK = 1'b0;
      end
      if (bus.GP9001CS && cs_cycles == ack_delay) begin
        bus.GP9001ACK  = 1'b1;
        bus.GP9001DOUT = gcu_data;
      end else if (!bus.GP9001ACK) begin
        bus.GP9001DOUT = 16'($urandom);
      end

      // CPU glue
      if (bus.CPU_CS && acks > 0 && cyc - ack_cyc >= cs_hold) bus.CPU_CS = 1'b0;

      if (!bus.CPU_CS && !bus.GP9001ACK && !bus.GP9001CS) begin
        settle++;
        if (settle >= 3) done = 1;
      end else begin
        settle = 0;
      end
    end

    check_val({name, ".finished"}, 32'(done), 32'd1);
    check_val({name, ".ack_count"}, 32'(acks), 32'd1);
    check_val({name, ".ack_latency"}, 32'(ack_cyc), 32'(exp_ack_cyc));
    check_val({name, ".gcu_txns"}, 32'(txn), mapped ? 32'd1 : 32'd0);
    check_val({name, ".cs_cycles"}, 32'(cs_cycles), 32'(exp_cs));
    check_val({name, ".cs_start"}, 32'(first_cs), mapped ? 32'd1 : 32'hFFFF_FFFF);
    check_val({name, ".op_flags"}, 32'(op_bad), 32'd0);
    check_val({name, ".gcu_din"}, 32'(din_bad), 32'd0);
    if (mapped || rnw) check_val({name, ".cpu_dout"}, 32'(dout), 32'(exp_dout));
    check_val({name, ".timeout_err"}, 32'(bus.TIMEOUT_ERR), 32'(exp_terr));
    $display("txn %-10s rnw=%0d addr=%0d din=%04h ackd=%0d -> cs=%0d ack@%0d dout=%04h terr=%0d",
             name, rnw, addr, din, ack_delay, cs_cycles, ack_cyc, dout, bus.TIMEOUT_ERR);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) op_map[i] = 6'b0;
    op_map[{1'b0, 3'd0}] = F_PTR;
    op_map[{1'b0, 3'd2}] = F_WRAM;
    op_map[{1'b0, 3'd3}] = F_WRAM;
    op_map[{1'b0, 3'd4}] = F_SELECT;
    op_map[{1'b0, 3'd6}] = F_WREG;
    op_map[{1'b1, 3'd2}] = F_RDH;
    op_map[{1'b1, 3'd3}] = F_RDL;

    RESET = 1'b1;
    bus.CPU_CS = 1'b0; bus.CPU_RNW = 1'b0; bus.CPU_ADDR = 3'd0; bus.CPU_DIN = 16'h0;
    bus.GP9001ACK = 1'b0; bus.GP9001DOUT = 16'h0;
    bus.CPU_HSYNC = 1'b0; bus.CPU_VSYNC = 1'b0; bus.CPU_FBLANK = 1'b0;
    repeat (3) @(negedge CLK);
    check_val("reset.cs", 32'(bus.GP9001CS), 32'd0);
    check_val("reset.flags", 32'(flags_now()), 32'd0);
    check_val("reset.cpu_ack", 32'(bus.CPU_ACK), 32'd0);
    check_val("reset.cpu_dout", 32'(bus.CPU_DOUT), 32'd0);
    check_val("reset.gcu_din", 32'(bus.GP9001DIN), 32'd0);
    check_val("reset.terr", 32'(bus.TIMEOUT_ERR), 32'd0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // Directed cases from the address map and timing rules
    do_access("ptr_wr",   1'b0, 3'd0, 16'h1234, 3, 0, 16'h0, 0);
    do_access("rd_h",     1'b1, 3'd2, 16'h5555, 5, 1, 16'hBEEF, 1);
    do_access("rd_l",     1'b1, 3'd3, 16'h0,    2, 0, 16'hC0DE, 0);
    bus.CPU_HSYNC = 1'b1; bus.CPU_VSYNC = 1'b0; bus.CPU_FBLANK = 1'b1;
    do_access("status",   1'b1, 3'd6, 16'h0,    0, 0, 16'h0, 0);
    do_access("ack_at_to", 1'b1, 3'd2, 16'h0,   TO, 0, 16'hA5A5, 0);
    do_access("sel_to",   1'b0, 3'd4, 16'h00AA, 0, 0, 16'h0, 0);
    do_access("unmap_rd", 1'b1, 3'd5, 16'h0,    0, 0, 16'h0, 0);
    do_access("unmap_wr", 1'b0, 3'd7, 16'h7777, 2, 0, 16'h0, 0);
    do_access("wreg_hold", 1'b0, 3'd6, 16'h4242, 2, 4, 16'h0, 20);

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      bus.CPU_HSYNC  = 1'($urandom);
      bus.CPU_VSYNC  = 1'($urandom);
      bus.CPU_FBLANK = 1'($urandom);
      do_access("rand", 1'($urandom), 3'($urandom), 16'($urandom),
                int'($urandom_range(0, TO + 2)), int'($urandom_range(0, 3)),
                16'($urandom), int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of a GCU request
    bus.CPU_CS = 1'b1; bus.CPU_RNW = 1'b0; bus.CPU_ADDR = 3'd4; bus.CPU_DIN = 16'h1111;
    repeat (3) @(negedge CLK);
    check_val("rst_mid.cs_before", 32'(bus.GP9001CS), 32'd1);
    #2 RESET = 1'b1;
    #1;
    check_val("rst_mid.cs", 32'(bus.GP9001CS), 32'd0);
    check_val("rst_mid.flags", 32'(flags_now()), 32'd0);
    check_val("rst_mid.cpu_ack", 32'(bus.CPU_ACK), 32'd0);
    check_val("rst_mid.terr", 32'(bus.TIMEOUT_ERR), 32'd0);
    exp_terr = 1'b0;
    bus.CPU_CS = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    check_val("rst_mid.idle_cs", 32'(bus.GP9001CS), 32'd0);
    $display("txn reset_mid_req done");
    bus.CPU_HSYNC = 1'b0; bus.CPU_VSYNC = 1'b1; bus.CPU_FBLANK = 1'b0;
    do_access("post_rst", 1'b1, 3'd6, 16'h0, 0, 0, 16'h0, 0);
    do_access("post_wr",  1'b0, 3'd2, 16'h9876, 1, 0, 16'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
